// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op encodings and FSM states for the RV32M multiply/divide sequencer.
package muldiv_pkg;
    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake between decode and the multiply/divide sequencer.
interface muldiv_if;
    import muldiv_pkg::*;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, kill, resp_ready,
        input  req_ready, resp_valid, resp_result
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-and-add multiply or restoring-divide iteration on {hi, lo}.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] md,
    output logic [XLEN-1:0] hi_n,
    output logic [XLEN-1:0] lo_n
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_s;
    logic [XLEN:0] trial;
    logic          ge;

    assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    assign rem_s = {hi, lo[XLEN-1]};
    assign trial = rem_s - {1'b0, md};
    // a shifted remainder with bit 32 set always exceeds any 32-bit divisor
    assign ge    = rem_s[XLEN] | ~trial[XLEN];

    always_comb begin
        hi_n = div ? (ge ? trial[XLEN-1:0] : rem_s[XLEN-1:0]) : sum[XLEN:1];
        lo_n = div ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M MUL/DIV/REM unit; magnitudes through an unsigned
// 32-step core with a final sign fix-up, returned over a valid/ready handshake.
module muldiv_seq
    import muldiv_pkg::*;
(
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   a, b, hi, lo, md, hi_n, lo_n;
    logic              neg;
    logic [4:0]        count;
    logic              is_div, a_sgn, b_sgn, div0, ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
    logic [2*XLEN-1:0] prod_fix;

    assign bus.req_ready = rst_n && state == S_IDLE;

    always_comb begin
        is_div      = op[2];
        a_sgn       = a[XLEN-1] & (op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        b_sgn       = b[XLEN-1] & (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
        a_mag       = a_sgn ? -a : a;
        b_mag       = b_sgn ? -b : b;
        div0        = b == '0;
        ovf         = (op == OP_DIV || op == OP_REM) && a == INT_MIN && b == ALL_ONES;
        special_res = div0 ? (op[1] ? a : ALL_ONES) : (op[1] ? '0 : INT_MIN);
        prod_fix    = neg ? -{hi, lo} : {hi, lo};
        fix_res     = is_div ? (op[1] ? (neg ? -hi : hi) : (neg ? -lo : lo))
                             : (op == OP_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    end

    muldiv_step u_step (
        .div  (is_div),
        .hi   (hi),
        .lo   (lo),
        .md   (md),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            op              <= '0;
            a               <= '0;
            b               <= '0;
            hi              <= '0;
            lo              <= '0;
            md              <= '0;
            neg             <= 1'b0;
            count           <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_result <= '0;
        end else if (state != S_IDLE && bus.kill) begin
            state          <= S_IDLE;
            bus.resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    op    <= bus.req_op;
                    a     <= bus.req_a;
                    b     <= bus.req_b;
                    state <= S_PREP;
                end
                S_PREP: begin
                    neg   <= (op == OP_REM) ? a_sgn : a_sgn ^ b_sgn;
                    hi    <= '0;
                    lo    <= is_div ? a_mag : b_mag;
                    md    <= is_div ? b_mag : a_mag;
                    count <= '0;
                    if (is_div && (div0 || ovf)) begin
                        bus.resp_result <= special_res;
                        bus.resp_valid  <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    hi    <= hi_n;
                    lo    <= lo_n;
                    count <= count + 5'd1;
                    if (count == 5'(ITERS - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    bus.resp_result <= fix_res;
                    bus.resp_valid  <= 1'b1;
                    state           <= S_DONE;
                end
                S_DONE: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table, handshake/kill/reset sequences and random ops
// against a 64-bit arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    muldiv_if bus ();
    muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        int ia = $signed(a);
        int ib = $signed(b);
        logic sovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OP_DIV:    return b == 0 ? 32'hFFFF_FFFF : sovf ? a : 32'(ia / ib);
            OP_DIVU:   return b == 0 ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return b == 0 ? a : sovf ? 32'd0 : 32'(ia % ib);
            default:   return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: bound expired waiting on DUT", name);
    endtask

    // entered and left #1 after a rising edge; the edge inside is the acceptance edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.req_ready) timeout("issue_ready");
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic await_resp(output logic [31:0] res, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.resp_valid && lat < 100);
        if (!bus.resp_valid) timeout("await_resp");
        res = bus.resp_result;
    endtask

    task automatic take();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat;
        issue(op, a, b);
        chk({name, "_busy"}, 32'(bus.req_ready), 32'd0);
        await_resp(res, lat);
        chk({name, "_res"}, res, exp);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        take();
        chk({name, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] hold;
        int lat;
        logic seen;

        vecs[0]  = '{OP_MUL,    32'd5,          32'd3,          32'd15,         34};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34};
        vecs[2]  = '{OP_MULH,   -32'sd7,        32'd3,          32'hFFFF_FFFF,  34};
        vecs[3]  = '{OP_DIV,    -32'sd7,        32'd2,          32'hFFFF_FFFD,  34};
        vecs[4]  = '{OP_REM,    -32'sd7,        32'd2,          32'hFFFF_FFFF,  34};
        vecs[5]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34};
        vecs[6]  = '{OP_DIVU,   32'd7,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[7]  = '{OP_REMU,   32'd7,          32'd0,          32'd7,          1};
        vecs[8]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[9]  = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[10] = '{OP_MUL,    -32'sd7,        32'd3,          32'hFFFF_FFEB,  34};
        vecs[11] = '{OP_DIV,    32'd1000,       -32'sd7,        32'hFFFF_FF72,  34};

        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.kill = 1'b0;
        bus.resp_ready = 1'b0;

        #12;
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_result", bus.resp_result, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // backpressure: result held for 10 cycles, then a new request right after the handshake
        issue(OP_MUL, 32'd6, 32'd7);
        await_resp(hold, lat);
        chk("bp_res", hold, 32'd42);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_stable", bus.resp_result, hold);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        take();
        chk("bp_idle", 32'(bus.req_ready), 32'd1);
        chk("bp_valid_drop", 32'(bus.resp_valid), 32'd0);
        run_op("bp_next", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);

        // kill while the iteration counter reads 10
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        chk("kill_idle", 32'(bus.req_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= bus.resp_valid;
            @(posedge clk); #1;
        end
        chk("kill_no_resp", 32'(seen), 32'd0);
        run_op("kill_next", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);

        // asynchronous reset mid-iteration
        issue(OP_MUL, 32'd123, 32'd456);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.resp_valid), 32'd0);
        chk("arst_result", bus.resp_result, 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_release", 32'(bus.req_ready), 32'd1);
        run_op("arst_next", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, a, b);
            await_resp(res, lat);
            chk($sformatf("rand%0d_op%0d_res", i, op), res, ref_model(op, a, b));
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(ref_lat(op, a, b)));
            take();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
